// File: rtl/challenge_recover.sv
// rtl/challenge_recover.sv - exhaustive forward search recovering every seed that scrambles to a challenge
module challenge_recover #(
    parameter int STEP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [7:0]        target_challenge,
    input  logic [STEP_W-1:0] num_steps,
    output logic              busy,
    output logic              found_valid,
    output logic [7:0]        found_seed,
    output logic [8:0]        match_count,
    output logic              done,
    output logic              aborted
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STEP,
        ST_CMP,
        ST_DONE
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [7:0]        tgt_lat;
    logic [STEP_W-1:0] n_lat;
    logic [STEP_W-1:0] step_cnt;
    logic [7:0]        seed_cnt;
    logic [7:0]        work;

    // One scrambler clock step; the map is linear and folds 0x00/0xFF together.
    function automatic logic [7:0] scr_step(input logic [7:0] c);
        logic nb;
        nb = c[0] ^ c[1] ^ c[2] ^ c[3] ^ c[7];
        return c ^ {nb, c[7:1]};
    endfunction

    // Next-state logic; abort wins over everything once a search is running.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (start) state_nx = ST_LOAD;
            ST_LOAD: begin
                if (abort)                   state_nx = ST_DONE;
                else if (n_lat != '0)        state_nx = ST_STEP;
                else                         state_nx = ST_CMP;
            end
            ST_STEP: begin
                if (abort)                                  state_nx = ST_DONE;
                else if (step_cnt == n_lat - STEP_W'(1))    state_nx = ST_CMP;
            end
            ST_CMP: begin
                if (abort)                   state_nx = ST_DONE;
                else if (seed_cnt == 8'hFF)  state_nx = ST_DONE;
                else                         state_nx = ST_LOAD;
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nx;
    end

    // Datapath: latch request, run the scrambler on the candidate, report matches.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tgt_lat     <= 8'h00;
            n_lat       <= '0;
            step_cnt    <= '0;
            seed_cnt    <= 8'h00;
            work        <= 8'h00;
            found_valid <= 1'b0;
            found_seed  <= 8'h00;
            match_count <= 9'd0;
            aborted     <= 1'b0;
        end else begin
            found_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        tgt_lat     <= target_challenge;
                        n_lat       <= num_steps;
                        seed_cnt    <= 8'h00;
                        match_count <= 9'd0;
                        aborted     <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    work     <= seed_cnt;
                    step_cnt <= '0;
                    if (abort) aborted <= 1'b1;
                end
                ST_STEP: begin
                    work     <= scr_step(work);
                    step_cnt <= step_cnt + STEP_W'(1);
                    if (abort) aborted <= 1'b1;
                end
                ST_CMP: begin
                    if (abort) begin
                        // A match in the abort cycle is dropped on purpose.
                        aborted <= 1'b1;
                    end else begin
                        if (work == tgt_lat) begin
                            found_valid <= 1'b1;
                            found_seed  <= seed_cnt;
                            match_count <= match_count + 9'd1;
                        end
                        if (seed_cnt != 8'hFF) seed_cnt <= seed_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == ST_LOAD) || (state == ST_STEP) || (state == ST_CMP);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_challenge_recover.sv
// tb/tb_challenge_recover.sv - randomized self-checking bench for challenge_recover
module tb_challenge_recover;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [7:0] target_challenge;
    logic [7:0] num_steps;
    logic       busy;
    logic       found_valid;
    logic [7:0] found_seed;
    logic [8:0] match_count;
    logic       done;
    logic       aborted;

    int n_checks = 0;
    int n_fail   = 0;

    challenge_recover #(.STEP_W(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .abort            (abort),
        .target_challenge (target_challenge),
        .num_steps        (num_steps),
        .busy             (busy),
        .found_valid      (found_valid),
        .found_seed       (found_seed),
        .match_count      (match_count),
        .done             (done),
        .aborted          (aborted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference scrambler: one step and N steps from the textual rule.
    function automatic logic [7:0] s_fn(input logic [7:0] c);
        logic nb;
        nb = c[0] ^ c[1] ^ c[2] ^ c[3] ^ c[7];
        return c ^ {nb, c[7:1]};
    endfunction

    function automatic logic [7:0] s_pow(input logic [7:0] c, input int n);
        logic [7:0] v;
        v = c;
        for (int k = 0; k < n; k++) v = s_fn(v);
        return v;
    endfunction

    // Called at a negedge; returns at a negedge.
    task automatic run_search(input string name, input logic [7:0] tgt, input int n,
                              input int abort_at, input int extra_at);
        logic [7:0] exp_q[$];
        int         exp_done;
        int         cyc;
        int         done_cyc;
        int         nfound;
        exp_q.delete();
        for (int s = 0; s < 256; s++) begin
            if (s_pow(8'(s), n) == tgt) begin
                if (abort_at == 0 || (s * (n + 2) + n + 2) < abort_at) exp_q.push_back(8'(s));
            end
        end
        exp_done = (abort_at != 0) ? abort_at + 1 : 256 * (n + 2) + 1;

        target_challenge = tgt;
        num_steps        = 8'(n);
        start            = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start            = 1'b0;
        target_challenge = 8'($urandom);
        num_steps        = 8'($urandom);
        cyc      = 1;
        done_cyc = 0;
        nfound   = 0;
        check({name, " busy_c1"}, busy, 1);
        check({name, " aborted_c1"}, aborted, 0);
        check({name, " count_c1"}, match_count, 0);
        while (cyc <= exp_done + 8 && done_cyc == 0) begin
            if (found_valid) begin
                if (nfound < exp_q.size()) check({name, " seed"}, found_seed, exp_q[nfound]);
                nfound++;
            end
            if (done) done_cyc = cyc;
            abort = (abort_at != 0 && cyc == abort_at);
            start = (extra_at != 0 && cyc == extra_at);
            if (done_cyc == 0) begin
                @(posedge clk);
                @(negedge clk);
                cyc++;
            end
        end
        abort = 1'b0;
        start = 1'b0;
        check({name, " done_cycle"}, done_cyc, exp_done);
        check({name, " nfound"}, nfound, exp_q.size());
        check({name, " match_count"}, match_count, exp_q.size());
        check({name, " aborted"}, aborted, (abort_at != 0) ? 1 : 0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            check({name, " idle_done"}, done, 0);
            check({name, " idle_busy"}, busy, 0);
            check({name, " idle_fv"}, found_valid, 0);
        end
        check({name, " hold_count"}, match_count, exp_q.size());
    endtask

    initial begin
        logic [7:0] sd;
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        target_challenge = 8'h00; num_steps = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst busy", busy, 0);
        check("rst fv", found_valid, 0);
        check("rst done", done, 0);
        check("rst aborted", aborted, 0);
        check("rst seed", found_seed, 0);
        check("rst count", match_count, 0);
        rst = 1'b1;
        @(negedge clk);

        run_search("n0_5a", 8'h5A, 0, 0, 0);
        run_search("n1_00", 8'h00, 1, 0, 0);
        run_search("n1_05", 8'h05, 1, 0, 0);
        run_search("n1_80", 8'h80, 1, 0, 0);
        sd = 8'($urandom);
        run_search("n3_rand", s_pow(sd, 3), 3, 0, 0);
        sd = 8'($urandom);
        run_search("abort", s_pow(sd, 4), 4, 100, 0);
        sd = 8'($urandom);
        run_search("busy_start", s_pow(sd, 1), 1, 0, 40);

        // Reset in the middle of a search, after leaving aborted set.
        sd = 8'($urandom);
        run_search("abort2", s_pow(sd, 2), 2, 37, 0);
        target_challenge = 8'h11; num_steps = 8'd2; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (50) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst busy", busy, 0);
        check("midrst fv", found_valid, 0);
        check("midrst done", done, 0);
        check("midrst aborted", aborted, 0);
        check("midrst seed", found_seed, 0);
        check("midrst count", match_count, 0);
        rst = 1'b1;
        sd = 8'($urandom);
        run_search("post_rst", s_pow(sd, 2), 2, 0, 0);

        sd = 8'($urandom);
        run_search("n255", s_pow(sd, 255), 255, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/challenge_recover.md
Name: challenge_recover

Overview:
- Inverse-side companion to the challenge Scrambler. Given a scrambled 8-bit challenge and the number of scrambler clock steps applied, it recovers every 8-bit seed that produces that challenge.
- The scrambler step is linear over GF(2) and not injective: 0x00 and 0xFF both map to 0x00, so every image has exactly 0 or 2 preimages. A direct inverse is therefore impossible, and the block performs an exhaustive forward search over all 256 seeds.
- It sits on the verifier side of the PUF challenge path and streams matching seeds out as they are found.

Parameters:
- STEP_W, 8, width of the step-count input; supports 0 to 2^STEP_W-1 scrambler steps.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-low; sampled on the rising edge of clk.
- start  input  1  request a search; accepted only in IDLE.
- abort  input  1  terminate a running search; ignored in IDLE and DONE.
- target_challenge  input  8  scrambled challenge to match; latched when start is accepted.
- num_steps  input  STEP_W  scrambler steps N; latched when start is accepted.
- busy  output  1  high in LOAD, STEP and CMP.
- found_valid  output  1  one-cycle pulse when a matching seed is found.
- found_seed  output  8  matching seed; updated with found_valid, holds otherwise.
- match_count  output  9  number of matches in the current or last search (0..256).
- done  output  1  one-cycle pulse when a search ends.
- aborted  output  1  set with done if the search was aborted; cleared on the next accepted start.

Behaviour:
- Step function S(c), bit-exact with the scrambler:
  - nb = c[0]^c[1]^c[2]^c[3]^c[7]
  - S(c) = c ^ {nb, c[7:1]}
  - After N steps, the scrambler output equals S^N(seed), with S^0 = identity.
- Reset (rst==0 at an edge): state goes to IDLE. busy, found_valid, done and aborted go to 0; found_seed goes to 0x00; match_count goes to 0. Latched target, steps and counters are cleared. Reset overrides every other input, including mid-search.
- IDLE:
  - On start==1: latch target_challenge and num_steps, set seed_cnt=0, clear match_count and aborted, go to LOAD.
  - Otherwise remain in IDLE.
- LOAD (1 cycle): work<=seed_cnt, step_cnt<=0. Go to STEP if latched N>0, else go to CMP.
- STEP (N cycles): work<=S(work), step_cnt<=step_cnt+1. Go to CMP in the cycle where step_cnt==N-1.
- CMP (1 cycle):
  - If work==target: found_valid=1, found_seed=seed_cnt, match_count+=1.
  - If seed_cnt==255: go to DONE.
  - Otherwise: seed_cnt+=1 and go to LOAD.
- DONE (1 cycle): done=1, go to IDLE. match_count, found_seed and aborted hold until the next accepted start.
- Latency:
  - Each seed costs N+2 cycles.
  - With start sampled at edge 0, done is high in cycle 256*(N+2)+1 (cycle 513 for N=0).
  - Seeds are reported in ascending order.
- Abort:
  - abort==1 in LOAD, STEP or CMP causes DONE on the next cycle with aborted=1.
  - Abort has priority over a match in the same CMP cycle: that match is not reported or counted.
- start while busy or in DONE is ignored; there is no queueing.
- start and abort together in IDLE: start is accepted and abort is ignored.
- match_count cannot overflow: at most 256 matches fit in 9 bits.
- num_steps changes after acceptance have no effect.

Test Plan:
- N=0, target 0x5A -> exactly one found_valid with found_seed=0x5A; done in cycle 513; match_count=1; aborted=0.
- N=1, target 0x00 -> found_seed 0x00 then 0xFF; match_count=2; done in cycle 769.
- N=1, target 0x05 -> found_seed 0x06 then 0xF9; match_count=2. Target 0x80 (bit7 ≠ bit0^bit2, so no preimage) -> no found_valid; match_count=0; done in cycle 769.
- N=3 and N=255, random target generated by a reference S^N model from a random seed -> the reported seed set exactly equals the model's preimage set; done at 256*(N+2)+1.
- Abort in cycle 100 of an N=4 search -> done one cycle later with aborted=1; no found_valid afterwards. A start pulsed while busy is ignored; a following start is accepted and clears aborted.
- rst=0 mid-search -> next cycle all outputs at reset values and state IDLE; start immediately after rst=1 runs a full correct search.
